pipe_out_fifo: RTL and testbench

PIPE_OUT_FIFO -- requirements
Module: pipe_out_fifo

---
 rtl/pipe_out_fifo.sv | 91 +++++++++
 tb/tb_pipe_out_fifo.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/pipe_out_fifo.sv
// pipe_out_fifo: first-word-fall-through output FIFO that absorbs an upstream
// shift-register pipeline. stall is raised early enough that the words still
// in flight upstream (up to PipeDepth) always fit into the remaining space.
module pipe_out_fifo #(
   parameter int unsigned DataWidth = 32,
   parameter int unsigned AddrWidth = 3,
   parameter int unsigned PipeDepth = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 din_valid,
   input  logic [DataWidth-1:0] din,
   output logic                 stall,
   output logic                 dout_valid,
   output logic [DataWidth-1:0] dout,
   input  logic                 dout_ready,
   output logic [AddrWidth:0]   count,
   output logic                 overflow
);

   localparam int unsigned Depth = 2 ** AddrWidth;
   localparam int unsigned CntW  = AddrWidth + 1;

   // Reject configurations where in-flight words could overrun the buffer
   generate
      if (Depth < PipeDepth + 2) begin : g_bad_params
         $error("pipe_out_fifo: Depth (2**AddrWidth) must be >= PipeDepth + 2");
      end
   endgenerate

   logic [DataWidth-1:0] mem [Depth];
   logic [AddrWidth-1:0] wr_ptr;
   logic [AddrWidth-1:0] rd_ptr;
   logic [CntW-1:0]      count_next;
   logic                 full_c;
   logic                 pop_c;
   logic                 push_c;
   logic                 drop_c;

   // Push/pop decisions and the post-edge occupancy
   always_comb begin
      full_c     = (count == CntW'(Depth));
      pop_c      = dout_valid & dout_ready;
      push_c     = din_valid & (~full_c | pop_c);
      drop_c     = din_valid & full_c & ~pop_c;
      count_next = count;
      if (push_c && !pop_c) begin
         count_next = count + CntW'(1);
      end else if (pop_c && !push_c) begin
         count_next = count - CntW'(1);
      end
   end

   // Pointers, occupancy, back-pressure and sticky overflow
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         dout_valid <= 1'b0;
         stall      <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         if (push_c) begin
            wr_ptr <= wr_ptr + AddrWidth'(1);
         end
         if (pop_c) begin
            rd_ptr <= rd_ptr + AddrWidth'(1);
         end
         count      <= count_next;
         dout_valid <= (count_next != '0);
         stall      <= ((CntW'(Depth) - count_next) <= CntW'(PipeDepth));
         if (drop_c) begin
            overflow <= 1'b1;
         end
      end
   end

   // Storage array; contents deliberately survive reset
   always_ff @(posedge clk) begin
      if (push_c) begin
         mem[wr_ptr] <= din;
      end
   end

   // Oldest word falls through with no added latency
   always_comb begin
      dout = mem[rd_ptr];
   end

endmodule

// File: tb/tb_pipe_out_fifo.sv
// Directed bench for pipe_out_fifo with a queue-based scoreboard on dout.
module tb_pipe_out_fifo;

   logic        clk = 1'b0;
   logic        rst;
   logic        din_valid;
   logic [31:0] din;
   logic        stall;
   logic        dout_valid;
   logic [31:0] dout;
   logic        dout_ready;
   logic [3:0]  count;
   logic        overflow;

   int total = 0;
   int bad   = 0;
   logic [31:0] exp_q [$];

   pipe_out_fifo #(.DataWidth(32), .AddrWidth(3), .PipeDepth(3)) dut (
      .clk        (clk),
      .rst        (rst),
      .din_valid  (din_valid),
      .din        (din),
      .stall      (stall),
      .dout_valid (dout_valid),
      .dout       (dout),
      .dout_ready (dout_ready),
      .count      (count),
      .overflow   (overflow)
   );

   always #5 clk = ~clk;

   // Monitor: every handshake seen before the edge must match the scoreboard head
   always @(negedge clk) begin
      if (rst === 1'b0 && dout_valid === 1'b1 && dout_ready === 1'b1) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL dout_unexpected: got %h, scoreboard empty", dout);
         end else begin
            logic [31:0] e;
            e = exp_q.pop_front();
            if (dout !== e) begin
               bad++;
               $display("FAIL dout_order: got %h expected %h", dout, e);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Apply inputs for one cycle; returns just after the edge
   task automatic drive(input logic v, input logic [31:0] d, input logic r, input logic accept);
      din_valid  = v;
      din        = d;
      dout_ready = r;
      if (accept) exp_q.push_back(d);
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input string name);
      int n = 0;
      while (count != 0 && n < 40) begin
         drive(1'b0, 32'h0, 1'b1, 1'b0);
         n++;
      end
      chk({name, "_drained"}, 32'(count), 32'd0);
      chk({name, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; din_valid = 1'b0; din = '0; dout_ready = 1'b0;
      #1;
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_dout_valid", 32'(dout_valid), 32'd0);
      chk("rst_stall", 32'(stall), 32'd0);
      chk("rst_overflow", 32'(overflow), 32'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // Fill to 5 with consumer blocked; stall rises on the 5th push
      for (int i = 1; i <= 5; i++) begin
         drive(1'b1, 32'(i), 1'b0, 1'b1);
         if (i == 4) chk("fill_stall_at4", 32'(stall), 32'd0);
      end
      chk("fill_count5", 32'(count), 32'd5);
      chk("fill_stall5", 32'(stall), 32'd1);
      drive(1'b0, 32'h0, 1'b1, 1'b0);
      chk("fill_count4", 32'(count), 32'd4);
      chk("fill_stall_drop", 32'(stall), 32'd0);
      drain("fill");

      // Full FIFO with simultaneous push and pop
      for (int i = 1; i <= 8; i++) drive(1'b1, 32'(i), 1'b0, 1'b1);
      chk("full_count8", 32'(count), 32'd8);
      drive(1'b1, 32'hA5A5A5A5, 1'b1, 1'b1);
      chk("simul_count", 32'(count), 32'd8);
      chk("simul_overflow", 32'(overflow), 32'd0);
      drain("simul");

      // Overflow: ninth word is dropped
      for (int i = 1; i <= 9; i++) begin
         drive(1'b1, 32'(i), 1'b0, (i <= 8));
         if (i == 8) chk("ovf_before", 32'(overflow), 32'd0);
      end
      chk("ovf_count", 32'(count), 32'd8);
      chk("ovf_flag", 32'(overflow), 32'd1);
      drain("ovf");
      chk("ovf_sticky", 32'(overflow), 32'd1);

      // Empty-FIFO reads are ignored; X on din without valid is harmless
      drive(1'b0, 32'hxxxxxxxx, 1'b1, 1'b0);
      drive(1'b0, 32'hxxxxxxxx, 1'b1, 1'b0);
      chk("idle_count", 32'(count), 32'd0);
      chk("idle_stall", 32'(stall), 32'd0);
      chk("idle_dout_valid", 32'(dout_valid), 32'd0);

      // Asynchronous reset in the middle of a cycle
      for (int i = 1; i <= 6; i++) drive(1'b1, 32'(i), 1'b0, 1'b1);
      chk("pre_rst_stall", 32'(stall), 32'd1);
      din_valid = 1'b0;
      #2 rst = 1'b1;
      exp_q.delete();
      #1;
      chk("arst_count", 32'(count), 32'd0);
      chk("arst_dout_valid", 32'(dout_valid), 32'd0);
      chk("arst_stall", 32'(stall), 32'd0);
      chk("arst_overflow", 32'(overflow), 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;

      // Streaming across pointer wrap
      for (int i = 1; i <= 20; i++) begin
         drive(1'b1, 32'(i), 1'b1, 1'b1);
         chk("stream_count_le1", 32'(count <= 4'd1), 32'd1);
         chk("stream_stall", 32'(stall), 32'd0);
      end
      drain("stream");

      // Reset mid-operation, then a single push reappears one cycle later
      for (int i = 0; i < 4; i++) drive(1'b1, 32'h10 + 32'(i), 1'b0, 1'b1);
      chk("mid_count4", 32'(count), 32'd4);
      din_valid = 1'b0;
      #1 rst = 1'b1;
      exp_q.delete();
      #1;
      chk("mid_rst_count", 32'(count), 32'd0);
      chk("mid_rst_dout_valid", 32'(dout_valid), 32'd0);
      #1 rst = 1'b0;
      drive(1'b1, 32'h77, 1'b0, 1'b1);
      chk("post_rst_valid", 32'(dout_valid), 32'd1);
      chk("post_rst_dout", dout, 32'h77);
      drain("post_rst");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
